// File: rtl/reverb_param_smoother.sv
// Ramps a PIO-driven control word toward its target one step per audio sample tick.
// Each step is a fixed fraction of the remaining distance, so param_out approaches the target without overshooting.
module reverb_param_smoother #(
  parameter int                DATA_W      = 16,
  parameter int                STEP_SHIFT  = 4,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] target_in,
  input  logic              sample_tick,
  output logic [DATA_W-1:0] param_out,
  output logic              ramping,
  output logic              settled
);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [DATA_W-1:0] param_q, param_d;
  logic              ramping_q, ramping_d;
  logic              settled_q, settled_d;

  logic              up;
  logic [DATA_W:0]   diff;
  logic [DATA_W:0]   step_raw;
  logic [DATA_W:0]   step;

  // The extra MSB keeps the distance exact across the full unsigned range.
  always_comb begin
    up       = (target_q > param_q);
    diff     = up ? ({1'b0, target_q} - {1'b0, param_q})
                  : ({1'b0, param_q} - {1'b0, target_q});
    step_raw = diff >> STEP_SHIFT;
    step     = (step_raw == '0) ? {{DATA_W{1'b0}}, 1'b1} : step_raw;
  end

  always_comb begin
    target_d  = target_in;
    param_d   = param_q;
    state_d   = state_q;
    settled_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (target_q != param_q) state_d = RAMP;
      end
      RAMP: begin
        if (target_q == param_q) begin
          state_d   = IDLE;
          settled_d = 1'b1;
        end else if (sample_tick) begin
          if (diff <= step) begin
            param_d   = target_q;
            state_d   = IDLE;
            settled_d = 1'b1;
          end else if (up) begin
            param_d = param_q + step[DATA_W-1:0];
          end else begin
            param_d = param_q - step[DATA_W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ramping_d = (state_d == RAMP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      target_q  <= RESET_VALUE;
      param_q   <= RESET_VALUE;
      ramping_q <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      param_q   <= param_d;
      ramping_q <= ramping_d;
      settled_q <= settled_d;
    end
  end

  assign param_out = param_q;
  assign ramping   = ramping_q;
  assign settled   = settled_q;

endmodule

// File: tb/tb_reverb_param_smoother.sv
// Directed bench for reverb_param_smoother: cycle table for short ramps plus sequences for long ramps,
// direction reversal and asynchronous reset.
module tb_reverb_param_smoother;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] target_in;
  logic        sample_tick;
  logic [15:0] param_out;
  logic        ramping;
  logic        settled;

  int total = 0;
  int passed = 0;
  logic [15:0] hist[$];

  typedef struct {
    logic [15:0] tgt;
    logic        tick;
    logic [15:0] exp_p;
    logic        exp_r;
    logic        exp_s;
  } vec_t;

  vec_t tv[14];

  reverb_param_smoother #(.DATA_W(16), .STEP_SHIFT(4), .RESET_VALUE(16'h0000)) dut (
    .clk(clk), .reset(reset), .target_in(target_in), .sample_tick(sample_tick),
    .param_out(param_out), .ramping(ramping), .settled(settled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic cyc(input logic t);
    sample_tick = t;
    @(posedge clk); #1;
  endtask

  // Drives a target, ticks every other clock until settled, and checks monotonicity, bounds and the pulse.
  task automatic ramp_to(input logic [15:0] tgt, input string nm);
    logic [15:0] start, prev;
    logic up;
    int sc;
    bit dir_ok, bnd_ok, done;
    start = param_out; prev = param_out; up = (tgt > start);
    sc = 0; dir_ok = 1; bnd_ok = 1; done = 0;
    hist.delete();
    target_in = tgt;
    for (int c = 0; c < 6000 && !done; c++) begin
      cyc(c % 2 == 0);
      if (param_out != prev) begin
        hist.push_back(param_out);
        if (up ? (param_out < prev) : (param_out > prev)) dir_ok = 0;
      end
      if (up ? (param_out < start || param_out > tgt) : (param_out > start || param_out < tgt)) bnd_ok = 0;
      if (settled) begin sc++; done = 1; end
      prev = param_out;
    end
    for (int c = 0; c < 4; c++) begin
      cyc(1'b1);
      if (settled) sc++;
      if (param_out != prev) bnd_ok = 0;
    end
    sample_tick = 1'b0;
    chk({nm, " settled_pulses"}, sc, 1);
    chk({nm, " monotonic"}, dir_ok, 1);
    chk({nm, " bounded"}, bnd_ok, 1);
    chk({nm, " final"}, param_out, tgt);
    chk({nm, " ramping_low"}, ramping, 0);
  endtask

  initial begin
    logic [15:0] peak, mx;
    logic [15:0] first_steps[5];
    bit reached, no_exceed;

    tv[0]  = '{16'h1003, 1'b1, 16'h1000, 1'b0, 1'b0};
    tv[1]  = '{16'h1003, 1'b1, 16'h1000, 1'b1, 1'b0};
    tv[2]  = '{16'h1003, 1'b1, 16'h1001, 1'b1, 1'b0};
    tv[3]  = '{16'h1003, 1'b0, 16'h1001, 1'b1, 1'b0};
    tv[4]  = '{16'h1003, 1'b1, 16'h1002, 1'b1, 1'b0};
    tv[5]  = '{16'h1003, 1'b1, 16'h1003, 1'b0, 1'b1};
    tv[6]  = '{16'h1003, 1'b1, 16'h1003, 1'b0, 1'b0};
    tv[7]  = '{16'h1008, 1'b0, 16'h1003, 1'b0, 1'b0};
    tv[8]  = '{16'h1008, 1'b0, 16'h1003, 1'b1, 1'b0};
    tv[9]  = '{16'h1003, 1'b1, 16'h1004, 1'b1, 1'b0};
    tv[10] = '{16'h1003, 1'b0, 16'h1004, 1'b1, 1'b0};
    tv[11] = '{16'h1004, 1'b0, 16'h1004, 1'b1, 1'b0};
    tv[12] = '{16'h1004, 1'b0, 16'h1004, 1'b0, 1'b1};
    tv[13] = '{16'h1004, 1'b1, 16'h1004, 1'b0, 1'b0};
    first_steps = '{16'h0100, 16'h01F0, 16'h02D1, 16'h03A3, 16'h0468};

    // 1. reset and idle at zero
    reset = 1'b1; target_in = 16'h0000; sample_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {param_out, ramping, settled}, 0);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cyc(c % 8 == 0);
      chk($sformatf("idle0 c%0d", c), {param_out, ramping, settled}, 0);
    end

    // 2. 0 -> 0x1000
    ramp_to(16'h1000, "up1000");
    for (int i = 0; i < 5; i++)
      chk($sformatf("up1000 step%0d", i), (hist.size() > i) ? {16'h0, hist[i]} : 32'hDEAD_BEEF, first_steps[i]);
    cyc(1'b0); cyc(1'b0);

    // 3. small steps, same-cycle tick, target moved onto current value
    for (int i = 0; i < 14; i++) begin
      target_in = tv[i].tgt;
      cyc(tv[i].tick);
      chk($sformatf("vec%0d param", i), param_out, tv[i].exp_p);
      chk($sformatf("vec%0d flags", i), {ramping, settled}, {tv[i].exp_r, tv[i].exp_s});
    end

    // 4. reversal mid-ramp
    ramp_to(16'h0000, "down0");
    target_in = 16'h1000; reached = 0;
    for (int c = 0; c < 3000 && !reached; c++) begin
      cyc(c % 2 == 0);
      if (param_out >= 16'h0800) reached = 1;
    end
    chk("rev reached_0800", reached, 1);
    peak = param_out;
    target_in = 16'h0000;
    cyc(1'b0);
    chk("rev hold", param_out, peak);
    cyc(1'b1);
    chk("rev first_down", param_out < peak, 1);
    chk("rev still_ramping", ramping, 1);
    mx = param_out; no_exceed = (param_out <= peak);
    ramp_to(16'h0000, "rev");
    foreach (hist[i]) if (hist[i] > mx) no_exceed = 0;
    chk("rev no_exceed", no_exceed, 1);

    // 5. full scale both ways
    ramp_to(16'hFFFF, "upFFFF");
    ramp_to(16'h0000, "downFFFF");

    // 6. async reset mid-ramp
    target_in = 16'h1000;
    for (int c = 0; c < 40; c++) cyc(c % 2 == 0);
    chk("rst premove", (param_out != 0) && ramping, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst async", {param_out, ramping, settled}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst held", {param_out, ramping, settled}, 0);
    ramp_to(16'h1000, "restart");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
